// File: rtl/nn_result_unloader.sv
// Snapshots ten accelerator class scores on a rising acc_ready, streams them one per beat over
// valid/ready and reports the argmax. Define SIGNED_SCORES_EN for a two's-complement argmax compare.
module nn_result_unloader #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acc_ready,
  input  logic [DATA_W-1:0] result0,
  input  logic [DATA_W-1:0] result1,
  input  logic [DATA_W-1:0] result2,
  input  logic [DATA_W-1:0] result3,
  input  logic [DATA_W-1:0] result4,
  input  logic [DATA_W-1:0] result5,
  input  logic [DATA_W-1:0] result6,
  input  logic [DATA_W-1:0] result7,
  input  logic [DATA_W-1:0] result8,
  input  logic [DATA_W-1:0] result9,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              class_valid,
  output logic [IDX_W-1:0]  class_idx,
  output logic [DATA_W-1:0] best_score,
  input  logic              class_ack,
  output logic              busy,
  output logic              overrun
);

  localparam int NumClasses = 10;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NumClasses - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e            state_q, state_d;
  logic              acc_ready_q;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] best_q, best_d;
  logic [IDX_W-1:0]  cls_q, cls_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] snap_q [NumClasses];
  logic [DATA_W-1:0] res [NumClasses];
  logic [DATA_W-1:0] cur;
  logic              acc_rise;
  logic              capture;
  logic              better;

  assign res[0] = result0;
  assign res[1] = result1;
  assign res[2] = result2;
  assign res[3] = result3;
  assign res[4] = result4;
  assign res[5] = result5;
  assign res[6] = result6;
  assign res[7] = result7;
  assign res[8] = result8;
  assign res[9] = result9;

  assign acc_rise = acc_ready & ~acc_ready_q;

  always_comb begin
    cur = '0;
    for (int i = 0; i < NumClasses; i++) begin
      if (idx_q == IDX_W'(i)) cur = snap_q[i];
    end
  end

`ifdef SIGNED_SCORES_EN
  assign better = $signed(cur) > $signed(best_q);
`else
  assign better = cur > best_q;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    best_d    = best_q;
    cls_d     = cls_q;
    overrun_d = overrun_q;
    capture   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (acc_rise) begin
          capture = 1'b1;
          idx_d   = '0;
          best_d  = '0;
          cls_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (acc_rise) overrun_d = 1'b1;
        if (out_ready) begin
          // Strict '>' keeps the lowest index on ties.
          if (idx_q == '0 || better) begin
            best_d = cur;
            cls_d  = idx_q;
          end
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LastIdx) state_d = StDone;
        end
      end
      StDone: begin
        if (acc_rise) overrun_d = 1'b1;
        if (class_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      acc_ready_q <= 1'b0;
      idx_q       <= '0;
      best_q      <= '0;
      cls_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_ready_q <= acc_ready;
      idx_q       <= idx_d;
      best_q      <= best_d;
      cls_q       <= cls_d;
      overrun_q   <= overrun_d;
    end
  end

  // Snapshot only matters while streaming, so it carries no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < NumClasses; i++) snap_q[i] <= res[i];
    end
  end

  assign out_valid   = (state_q == StScan);
  assign out_data    = out_valid ? cur : '0;
  assign out_idx     = out_valid ? idx_q : '0;
  assign out_last    = out_valid && (idx_q == LastIdx);
  assign class_valid = (state_q == StDone);
  assign class_idx   = cls_q;
  assign best_score  = best_q;
  assign busy        = (state_q != StIdle);
  assign overrun     = overrun_q;

endmodule
